// File: rtl/v33_bus_responder.sv
// V33 external-bus target: decodes CPU bus cycles and answers from a word RAM with programmable wait states.
// Optional V33_RESP_IO_EN macro: when defined, I/O cycles (m_io=0) in the window are also accepted.
module v33_bus_responder #(
  parameter int          MEM_AW      = 10,
  parameter logic [23:0] ADDR_BASE   = 24'h000000,
  parameter logic [23:0] ADDR_MASK   = 24'hFFF800,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ce_1,
  input  logic        ce_2,
  input  logic [23:0] addr,
  input  logic [15:0] wdata,
  input  logic        n_bcyst,
  input  logic        n_dstb,
  input  logic        r_w,
  input  logic        m_io,
  input  logic        n_ube,
  output logic        n_ready,
  output logic        bs16,
  output logic [15:0] rdata,
  output logic        rdata_oe,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a cycle opens on a ce_1 edge with n_bcyst=0 and a selected
  // address; the target signals ready with n_ready=0 and the cycle closes on
  // the ce_1 edge where n_dstb=0 is seen while ready. The target then waits
  // for n_dstb=1 before accepting another cycle.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_HOLD} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [MEM_AW-1:0]   lat_idx;
  logic                lat_read;
  logic                lat_lo;
  logic                lat_hi;
  logic                io_ok;
  logic                sel;
  logic                start;
  logic                commit;
  logic [MEM_AW-1:0]   cur_idx;
  logic [15:0]         mem [0:(1<<MEM_AW)-1];

`ifdef V33_RESP_IO_EN
  assign io_ok = 1'b1;
`else
  assign io_ok = m_io;
`endif

  assign sel       = !n_bcyst && io_ok && ((addr & ADDR_MASK) == ADDR_BASE);
  assign start     = (state == S_IDLE) && sel;
  assign cur_idx   = addr[MEM_AW:1];
  assign commit    = ce_1 && (state == S_READY) && !n_dstb && !lat_read;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      lat_idx  <= '0;
      lat_read <= 1'b0;
      lat_lo   <= 1'b0;
      lat_hi   <= 1'b0;
      n_ready  <= 1'b1;
      bs16     <= 1'b0;
      rdata    <= '0;
      rdata_oe <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (ce_1) begin
        case (state)
          S_IDLE: begin
            if (sel) begin
              lat_idx  <= cur_idx;
              lat_read <= r_w;
              lat_lo   <= !addr[0];
              lat_hi   <= !n_ube;
              wait_cnt <= WS;
              busy     <= 1'b1;
              bs16     <= 1'b1;
              if (WS == 4'd0) begin
                state    <= S_READY;
                n_ready  <= 1'b0;
                rdata_oe <= r_w;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            // Count of 1 means this is the last TW; ready is registered so it shows in the next state.
            if (wait_cnt <= 4'd1) begin
              state    <= S_READY;
              wait_cnt <= '0;
              n_ready  <= 1'b0;
              rdata_oe <= lat_read;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
          S_READY: begin
            if (!n_dstb) begin
              state   <= S_HOLD;
              n_ready <= 1'b1;
            end
          end
          S_HOLD: begin
            if (n_dstb) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              bs16     <= 1'b0;
              rdata    <= rdata;
              rdata_oe <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (ce_2) begin
        if (ce_1 && start && r_w)
          rdata <= mem[cur_idx];
        else if (((state == S_WAIT) || (state == S_READY)) && lat_read)
          rdata <= mem[lat_idx];
      end
    end
  end

  // RAM is never cleared; a commit edge that coincides with reset is suppressed.
  always_ff @(posedge clk) begin
    if (commit && n_reset) begin
      if (lat_lo) mem[lat_idx][7:0]  <= wdata[7:0];
      if (lat_hi) mem[lat_idx][15:8] <= wdata[15:8];
    end
  end

endmodule

// File: tb/tb_v33_bus_responder.sv
// Bench for v33_bus_responder: three targets (0, 2, 3 wait states) share one CPU bus and a reference RAM model.
module tb_v33_bus_responder;

  localparam int          NI   = 3;
  localparam logic [23:0] BASE = 24'h000000;
  localparam logic [23:0] MASK = 24'hFF0000;
`ifdef V33_RESP_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        ce_1 = 1'b0;
  logic        ce_2 = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        n_bcyst = 1'b1;
  logic        n_dstb = 1'b1;
  logic        r_w = 1'b1;
  logic        m_io = 1'b1;
  logic        n_ube = 1'b1;

  logic        n_ready_v [NI];
  logic        bs16_v [NI];
  logic [15:0] rdata_v [NI];
  logic        rdata_oe_v [NI];
  logic        busy_v [NI];
  logic [1:0]  state_v [NI];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ref_mem [1024];
  int          pool [16] = '{16, 32, 128, 0, 1, 5, 77, 200, 255, 256, 511, 512, 700, 900, 1022, 1023};

  // ---------------- clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    v33_bus_responder #(
      .MEM_AW(10), .ADDR_BASE(BASE), .ADDR_MASK(MASK), .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2), .addr(addr), .wdata(wdata),
      .n_bcyst(n_bcyst), .n_dstb(n_dstb), .r_w(r_w), .m_io(m_io), .n_ube(n_ube),
      .n_ready(n_ready_v[g]), .bs16(bs16_v[g]), .rdata(rdata_v[g]), .rdata_oe(rdata_oe_v[g]),
      .busy(busy_v[g]), .state_dbg(state_v[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  // ---------------- scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s n_ready[%0d]", tag, i), 32'(n_ready_v[i]), 32'd1);
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s bs16[%0d]", tag, i), 32'(bs16_v[i]), 32'd0);
      check($sformatf("%s rdata_oe[%0d]", tag, i), 32'(rdata_oe_v[i]), 32'd0);
    end
  endtask

  // ---------------- drivers (called at a negedge, return at a negedge)
  task automatic tick();
    int gap;
    gap = $urandom_range(0, 2);
    ce_1 = 1'b0;
    ce_2 = 1'b0;
    repeat (gap) @(negedge clk);
    ce_1 = 1'b1;
    ce_2 = 1'b1;
    @(negedge clk);
    ce_1 = 1'b0;
    ce_2 = 1'b0;
  endtask

  task automatic bus_cycle(input logic [23:0] a, input bit rd, input bit mio, input bit nube,
                           input logic [15:0] wd, input bit do_reset, input string tag);
    bit          sel;
    int          idx;
    logic [15:0] exp_rd;
    sel    = ((a & MASK) == BASE) && (mio || IO_EN);
    idx    = int'((a / 2) % 1024);
    exp_rd = ref_mem[idx];

    n_bcyst = 1'b0; addr = a; r_w = rd; m_io = mio; n_ube = nube; wdata = wd; n_dstb = 1'b1;
    tick();
    n_bcyst = 1'b1;
    n_dstb  = 1'b0;

    if (!sel) begin
      for (int t = 0; t < 4; t++) begin
        check_idle($sformatf("%s unsel t%0d", tag, t));
        tick();
      end
      n_dstb = 1'b1;
      tick();
      return;
    end

    if (do_reset) begin
      #2 n_reset = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
        check($sformatf("%s rst rdata[%0d]", tag, i), 32'(rdata_v[i]), 32'd0);
        check($sformatf("%s rst state[%0d]", tag, i), 32'(state_v[i]), 32'd0);
      end
      check_idle($sformatf("%s rst", tag));
      @(negedge clk);
      tick();
      n_reset = 1'b1;
      n_dstb  = 1'b1;
      tick();
      check_idle($sformatf("%s after rst", tag));
      return;
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("%s n_ready[%0d] t%0d", tag, i, t), 32'(n_ready_v[i]), (t == ws_of(i)) ? 32'd0 : 32'd1);
        check($sformatf("%s busy[%0d] t%0d", tag, i, t), 32'(busy_v[i]), 32'd1);
        check($sformatf("%s bs16[%0d] t%0d", tag, i, t), 32'(bs16_v[i]), 32'd1);
        check($sformatf("%s rdata_oe[%0d] t%0d", tag, i, t), 32'(rdata_oe_v[i]),
              (rd && t >= ws_of(i)) ? 32'd1 : 32'd0);
        if (rd && t >= ws_of(i))
          check($sformatf("%s rdata[%0d] t%0d", tag, i, t), 32'(rdata_v[i]), 32'(exp_rd));
      end
      n_bcyst = 1'($urandom_range(0, 1));
      tick();
    end

    if (!rd) begin
      if (a % 2 == 0) ref_mem[idx][7:0]  = wd[7:0];
      if (!nube)      ref_mem[idx][15:8] = wd[15:8];
    end
    n_bcyst = 1'b1;
    n_dstb  = 1'b1;
    tick();
    check_idle($sformatf("%s end", tag));
  endtask

  // ---------------- stimulus
  initial begin
    logic [23:0] a;
    int          p;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check($sformatf("reset rdata[%0d]", i), 32'(rdata_v[i]), 32'd0);
    check_idle("reset");
    n_reset = 1'b1;
    @(negedge clk);

    // Directed cases
    bus_cycle(24'h000020, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, "pre_beef");
    bus_cycle(24'h000020, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_beef");
    bus_cycle(24'h000100, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, "wr_1234");
    bus_cycle(24'h000100, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_1234");
    bus_cycle(24'h000040, 1'b0, 1'b1, 1'b0, 16'h5566, 1'b0, "pre_5566");
    bus_cycle(24'h000041, 1'b0, 1'b1, 1'b0, 16'hAB00, 1'b0, "wr_hi");
    bus_cycle(24'h000040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_ab66");
    check("model ab66", 32'(ref_mem[32]), 32'h0000AB66);
    bus_cycle(24'h000040, 1'b0, 1'b1, 1'b1, 16'h00CD, 1'b0, "wr_lo");
    bus_cycle(24'h000040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_abcd");
    check("model abcd", 32'(ref_mem[32]), 32'h0000ABCD);
    bus_cycle(24'h100000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "outside");
    bus_cycle(24'h000100, 1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b1, "wr_rst");
    bus_cycle(24'h000100, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "rd_after_rst");
    bus_cycle(24'h000020, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, "io_rd");
    bus_cycle(24'h000820, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, "alias_rd");

    // Seed the rest of the pool so every random read has a known value
    for (int k = 0; k < 16; k++)
      if (pool[k] != 16 && pool[k] != 32 && pool[k] != 128)
        bus_cycle(24'(pool[k] * 2), 1'b0, 1'b1, 1'b0, 16'($urandom), 1'b0, "seed");

    // Randomized cycles
    for (int n = 0; n < 120; n++) begin
      p = pool[$urandom_range(0, 15)];
      a = 24'((int'($urandom_range(0, 31)) << 11) | (p << 1) | int'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) a = a | 24'h010000 | 24'(($urandom_range(1, 255)) << 16);
      bus_cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                16'($urandom), ($urandom_range(0, 15) == 0), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
